// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter: FSM encoding, owner IDs
// and default timing constants.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned MEM_LAT_DEF    = 4;
  localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/arb_lat_ctr.sv
// Loadable 4-bit down-counter with a zero flag. Holds at zero; a load wins
// over a decrement.
module arb_lat_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  // Counter register: load, else decrement toward zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified main memory between the fetch miss path (F) and the
// memory-stage miss/writeback path (D), one transaction at a time, and
// sequences the fixed memory latency.
//
// Handshake: a requester raises req with its addr/wr/wdata and holds req until
// it sees its one-cycle done pulse; command fields are captured at grant, so
// later changes are ignored. stall = req & ~done, so the pipeline can stall
// directly on it. Requesters drop req in the cycle after done, which the
// arbiter spends in HOLD ignoring requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_done,
  output logic [15:0] f_rdata,
  output logic        f_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err,
  output logic        owner_d,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic        grant_any;
  logic        grant_d;
  logic [15:0] sel_addr;
  logic        sel_mis;
  logic        take_grant;
  logic        ctr_load;
  logic        ctr_dec;
  logic        capture;
  logic        lat_zero;
  logic        cur_wr;
  logic [7:0]  starve;

  // Arbitration decision; only acted upon while idle. D wins ties until F has
  // waited through STARVE_MAX consecutive D grants.
  always_comb begin
    grant_any = f_req | d_req;
    grant_d   = d_req & (~f_req | (starve < 8'(STARVE_MAX)));
    sel_addr  = grant_d ? d_addr : f_addr;
    sel_mis   = sel_addr[0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; a misaligned grant skips the memory access.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (grant_any) next_state = sel_mis ? S_RESP : S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (lat_zero) next_state = S_RESP;
      S_RESP:  next_state = S_HOLD;
      S_HOLD:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM control outputs decoded from the current state.
  always_comb begin
    take_grant = (state == S_IDLE) & grant_any;
    ctr_load   = (state == S_ISSUE);
    ctr_dec    = (state == S_WAIT);
    capture    = (state == S_WAIT) & lat_zero;
    dbg_state  = state;
  end

  arb_lat_ctr u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (LAT_LOAD),
    .dec      (ctr_dec),
    .zero     (lat_zero)
  );

  // Memory command, done/err pulses and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
      owner_d   <= OWN_F;
      cur_wr    <= 1'b0;
    end else begin
      mem_en <= take_grant & ~sel_mis;
      mem_wr <= take_grant & ~sel_mis & grant_d & d_wr;
      f_done <= (capture & (owner_d == OWN_F)) | (take_grant & sel_mis & ~grant_d);
      d_done <= (capture & (owner_d == OWN_D)) | (take_grant & sel_mis & grant_d);
      err    <= take_grant & sel_mis;
      if (take_grant) begin
        owner_d <= grant_d ? OWN_D : OWN_F;
        cur_wr  <= grant_d & d_wr;
        if (!sel_mis) begin
          mem_addr  <= sel_addr;
          mem_wdata <= grant_d ? d_wdata : '0;
        end
      end
      if (capture) begin
        if (owner_d == OWN_F) begin
          f_rdata <= mem_rdata;
        end else if (!cur_wr) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  // Starvation counter: F grants clear it, D grants that beat a waiting F bump it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (take_grant) begin
      if (!grant_d) begin
        starve <= '0;
      end else if (f_req) begin
        starve <= starve + 8'd1;
      end
    end
  end

  assign f_stall = f_req & ~f_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int LAT  = 4;
  localparam int SMAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT (MEM_LAT = 4) ----------------
  logic        f_req, d_req, d_wr;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_done, f_stall, d_done, d_stall;
  logic [15:0] f_rdata, d_rdata;
  logic        mem_en, mem_wr, err, owner_d;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_stall(f_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err), .owner_d(owner_d), .dbg_state(dbg_state)
  );

  // ---------------- DUT (MEM_LAT = 1) ----------------
  logic        l1_f_req;
  logic [15:0] l1_f_addr;
  logic        l1_f_done, l1_f_stall, l1_d_done, l1_d_stall;
  logic [15:0] l1_f_rdata, l1_d_rdata;
  logic        l1_mem_en, l1_mem_wr, l1_err, l1_owner_d;
  logic [15:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [2:0]  l1_dbg_state;
  logic        l1_d_req = 1'b0;
  logic        l1_d_wr = 1'b0;
  logic [15:0] l1_d_addr = 16'h0;
  logic [15:0] l1_d_wdata = 16'h0;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .rst(rst),
    .f_req(l1_f_req), .f_addr(l1_f_addr), .f_done(l1_f_done), .f_rdata(l1_f_rdata), .f_stall(l1_f_stall),
    .d_req(l1_d_req), .d_wr(l1_d_wr), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_done(l1_d_done), .d_rdata(l1_d_rdata), .d_stall(l1_d_stall),
    .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .err(l1_err), .owner_d(l1_owner_d), .dbg_state(l1_dbg_state)
  );

  // ---------------- memory environment ----------------
  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  logic [15:0] env_mem [logic [15:0]];
  int          pend = 0;
  logic [15:0] pend_data;
  int          l1_pend = 0;
  logic [15:0] l1_pend_data;

  function automatic logic [15:0] env_rd(input logic [15:0] a);
    return env_mem.exists(a) ? env_mem[a] : mem_init(a);
  endfunction

  // Read data is valid only in the cycle MEM_LAT after mem_en; junk otherwise.
  always @(negedge clk) begin
    if (pend > 0) begin
      pend = pend - 1;
      mem_rdata = (pend == 0) ? pend_data : 16'($urandom);
    end else begin
      mem_rdata = 16'($urandom);
    end
    if (mem_en) begin
      if (mem_wr) env_mem[mem_addr] = mem_wdata;
      pend_data = env_rd(mem_addr);
      pend = LAT;
    end
    if (l1_pend > 0) begin
      l1_pend = l1_pend - 1;
      l1_mem_rdata = (l1_pend == 0) ? l1_pend_data : 16'($urandom);
    end else begin
      l1_mem_rdata = 16'($urandom);
    end
    if (l1_mem_en) begin
      l1_pend_data = mem_init(l1_mem_addr);
      l1_pend = 1;
    end
  end

  // ---------------- reference model + scoreboard (random run) ----------------
  logic [17:0] exp_q[$];
  logic [15:0] ref_mem [logic [15:0]];
  bit          rand_on = 1'b0;
  bit          busy;
  int          free_at, g_cyc, done_cyc, starve_m;
  bit          g_own, g_err, g_wr;
  logic [15:0] g_addr, g_wdata, last_f, last_d;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  always @(negedge clk) begin
    bit exp_men, exp_fd, exp_dd, exp_er;
    logic [17:0] got, e;
    logic [15:0] rd;
    if (rand_on) begin
      exp_men = busy && !g_err && (cyc == g_cyc + 1);
      exp_fd  = busy && (cyc == done_cyc) && !g_own;
      exp_dd  = busy && (cyc == done_cyc) && g_own;
      exp_er  = busy && (cyc == done_cyc) && g_err;
      checks++;
      if (mem_en !== exp_men) begin errors++; $display("FAIL rnd_mem_en cyc=%0d got %b exp %b", cyc, mem_en, exp_men); end
      if (exp_men) begin
        checks++;
        if ({mem_wr, mem_addr} !== {g_wr, g_addr}) begin errors++; $display("FAIL rnd_mem_cmd cyc=%0d got %b/%h exp %b/%h", cyc, mem_wr, mem_addr, g_wr, g_addr); end
        if (g_wr) begin
          checks++;
          if (mem_wdata !== g_wdata) begin errors++; $display("FAIL rnd_mem_wdata cyc=%0d got %h exp %h", cyc, mem_wdata, g_wdata); end
        end
      end
      if (busy && (cyc == g_cyc + 1)) begin
        checks++;
        if (owner_d !== g_own) begin errors++; $display("FAIL rnd_owner cyc=%0d got %b exp %b", cyc, owner_d, g_own); end
      end
      checks++;
      if ({f_done, d_done, err} !== {exp_fd, exp_dd, exp_er}) begin errors++; $display("FAIL rnd_done cyc=%0d got f%b d%b e%b exp f%b d%b e%b", cyc, f_done, d_done, err, exp_fd, exp_dd, exp_er); end
      checks++;
      if ({f_stall, d_stall} !== {f_req & ~exp_fd, d_req & ~exp_dd}) begin errors++; $display("FAIL rnd_stall cyc=%0d got %b%b exp %b%b", cyc, f_stall, d_stall, f_req & ~exp_fd, d_req & ~exp_dd); end
      if (busy && (cyc == done_cyc)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_queue cyc=%0d got empty exp entry", cyc);
        end else begin
          e   = exp_q.pop_front();
          got = {d_done, err, d_done ? d_rdata : f_rdata};
          if (got !== e) begin errors++; $display("FAIL rnd_resp cyc=%0d got %h exp %h", cyc, got, e); end
        end
        busy = 1'b0;
      end
      if (!busy && (cyc >= free_at) && (f_req || d_req)) begin
        g_own = d_req && (!f_req || (starve_m < SMAX));
        if (!g_own) starve_m = 0;
        else if (f_req) starve_m++;
        g_addr  = g_own ? d_addr : f_addr;
        g_wr    = g_own && d_wr;
        g_wdata = d_wdata;
        g_err   = g_addr[0];
        if (g_err || g_wr) rd = g_own ? last_d : last_f;
        else rd = ref_rd(g_addr);
        if (g_wr && !g_err) ref_mem[g_addr] = g_wdata;
        if (g_own) last_d = rd; else last_f = rd;
        exp_q.push_back({g_own, g_err, rd});
        busy     = 1'b1;
        g_cyc    = cyc;
        done_cyc = g_err ? cyc + 1 : cyc + LAT + 2;
        free_at  = g_err ? cyc + 3 : cyc + LAT + 4;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; l1_f_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 15)) << 1;
    if ($urandom_range(0, 7) == 0) a = a | 16'd1;
    return a;
  endfunction

  task automatic drive_f(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1; f_addr = rand_addr(); f_req = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!f_done && w < 100);
      if (!f_done) begin
        checks++; errors++; $display("FAIL drv_f_timeout got no f_done exp f_done within 100 cycles");
        f_req = 1'b0; return;
      end
      @(posedge clk); #1; f_req = 1'b0;
    end
  endtask

  task automatic drive_d(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1; d_addr = rand_addr(); d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom); d_req = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!d_done && w < 100);
      if (!d_done) begin
        checks++; errors++; $display("FAIL drv_d_timeout got no d_done exp d_done within 100 cycles");
        d_req = 1'b0; return;
      end
      @(posedge clk); #1; d_req = 1'b0;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, f_done, d_done, f_rdata, d_rdata, err, owner_d} !== '0)
      begin errors++; $display("FAIL reset_outputs got %b%b %h %h %b%b %h %h %b%b exp all zero", mem_en, mem_wr, mem_addr, mem_wdata, f_done, d_done, f_rdata, d_rdata, err, owner_d); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_d_read();
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040; end
      if (c == 7) d_req = 1'b0;
      @(negedge clk);
      checks++; if (mem_en !== (c == 1)) begin errors++; $display("FAIL dread_mem_en c=%0d got %b exp %b", c, mem_en, c == 1); end
      if (c == 1) begin
        checks++; if ({mem_wr, mem_addr, owner_d} !== {1'b0, 16'h0040, 1'b1}) begin errors++; $display("FAIL dread_cmd got wr=%b addr=%h own=%b exp 0/0040/1", mem_wr, mem_addr, owner_d); end
      end
      checks++; if (d_done !== (c == 6)) begin errors++; $display("FAIL dread_done c=%0d got %b exp %b", c, d_done, c == 6); end
      if (c == 6) begin
        checks++; if (d_rdata !== 16'hBEEF) begin errors++; $display("FAIL dread_rdata got %h exp BEEF", d_rdata); end
      end
      checks++; if (f_done !== 1'b0) begin errors++; $display("FAIL dread_fdone c=%0d got %b exp 0", c, f_done); end
      checks++; if (d_stall !== (c <= 5)) begin errors++; $display("FAIL dread_stall c=%0d got %b exp %b", c, d_stall, c <= 5); end
    end
  endtask

  task automatic test_d_write();
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234; end
      if (c == 7) begin d_req = 1'b0; d_wr = 1'b0; end
      @(negedge clk);
      checks++; if (mem_en !== (c == 1)) begin errors++; $display("FAIL dwrite_mem_en c=%0d got %b exp %b", c, mem_en, c == 1); end
      if (c == 1) begin
        checks++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0100, 16'h1234}) begin errors++; $display("FAIL dwrite_cmd got %b/%h/%h exp 1/0100/1234", mem_wr, mem_addr, mem_wdata); end
      end
      checks++; if (d_done !== (c == 6)) begin errors++; $display("FAIL dwrite_done c=%0d got %b exp %b", c, d_done, c == 6); end
      if (c == 6) begin
        checks++; if (d_rdata !== 16'hBEEF) begin errors++; $display("FAIL dwrite_rdata_kept got %h exp BEEF", d_rdata); end
      end
    end
  endtask

  task automatic test_f_misaligned();
    for (int c = 0; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin f_req = 1'b1; f_addr = 16'h0003; end
      if (c == 2) f_req = 1'b0;
      @(negedge clk);
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL ferr_mem_en c=%0d got %b exp 0", c, mem_en); end
      checks++; if ({f_done, err, d_done} !== {c == 1, c == 1, 1'b0}) begin errors++; $display("FAIL ferr_done c=%0d got f%b e%b d%b exp f%b e%b d0", c, f_done, err, d_done, c == 1, c == 1); end
      checks++; if (f_stall !== (c == 0)) begin errors++; $display("FAIL ferr_stall c=%0d got %b exp %b", c, f_stall, c == 0); end
      if (c == 1) begin
        checks++; if (f_rdata !== 16'h0000) begin errors++; $display("FAIL ferr_rdata_kept got %h exp 0000", f_rdata); end
      end
      if (c == 2) begin
        checks++; if (dbg_state !== 3'd4) begin errors++; $display("FAIL ferr_hold got %0d exp 4", dbg_state); end
      end
      if (c == 3) begin
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL ferr_idle got %0d exp 0", dbg_state); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0050; end
      if (c == 3) rst = 1'b1;
      if (c == 4) begin rst = 1'b0; d_req = 1'b0; end
      if (c == 5) begin f_req = 1'b1; f_addr = 16'h0060; end
      if (c == 12) f_req = 1'b0;
      @(negedge clk);
      checks++; if (mem_en !== (c == 1 || c == 6)) begin errors++; $display("FAIL rmid_mem_en c=%0d got %b exp %b", c, mem_en, c == 1 || c == 6); end
      checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL rmid_ddone c=%0d got %b exp 0", c, d_done); end
      checks++; if (f_done !== (c == 11)) begin errors++; $display("FAIL rmid_fdone c=%0d got %b exp %b", c, f_done, c == 11); end
      if (c == 4) begin
        checks++;
        if ({dbg_state, mem_wr, mem_addr, mem_wdata, f_rdata, d_rdata, err, owner_d} !== '0)
          begin errors++; $display("FAIL rmid_cleared got st=%0d %b %h %h %h %h %b %b exp all zero", dbg_state, mem_wr, mem_addr, mem_wdata, f_rdata, d_rdata, err, owner_d); end
      end
      if (c == 11) begin
        checks++; if (f_rdata !== mem_init(16'h0060)) begin errors++; $display("FAIL rmid_frdata got %h exp %h", f_rdata, mem_init(16'h0060)); end
      end
    end
  endtask

  task automatic test_lat1();
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin l1_f_req = 1'b1; l1_f_addr = 16'h0010; end
      if (c == 4) l1_f_req = 1'b0;
      @(negedge clk);
      checks++; if (l1_mem_en !== (c == 1)) begin errors++; $display("FAIL lat1_mem_en c=%0d got %b exp %b", c, l1_mem_en, c == 1); end
      checks++; if (l1_f_done !== (c == 3)) begin errors++; $display("FAIL lat1_done c=%0d got %b exp %b", c, l1_f_done, c == 3); end
      checks++; if (l1_f_stall !== (c <= 2)) begin errors++; $display("FAIL lat1_stall c=%0d got %b exp %b", c, l1_f_stall, c <= 2); end
      if (c == 3) begin
        checks++; if (l1_f_rdata !== mem_init(16'h0010)) begin errors++; $display("FAIL lat1_rdata got %h exp %h", l1_f_rdata, mem_init(16'h0010)); end
      end
    end
  endtask

  task automatic test_starvation();
    do_reset();
    for (int c = 0; c <= 47; c++) begin
      bit g, own_exp;
      @(posedge clk); #1;
      d_req = !(c == 7 || c == 15 || c == 23 || c >= 39);
      f_req = !(c == 31 || c >= 47);
      d_wr = 1'b0; d_addr = 16'h0030; f_addr = 16'h0020;
      @(negedge clk);
      g = (c >= 1) && (c <= 41) && ((c - 1) % 8 == 0);
      checks++; if (mem_en !== g) begin errors++; $display("FAIL starve_mem_en c=%0d got %b exp %b", c, mem_en, g); end
      if (g) begin
        own_exp = !(c == 25 || c == 41);
        checks++; if (owner_d !== own_exp) begin errors++; $display("FAIL starve_owner c=%0d got %b exp %b", c, owner_d, own_exp); end
      end
      checks++; if (f_done !== (c == 30 || c == 46)) begin errors++; $display("FAIL starve_fdone c=%0d got %b exp %b", c, f_done, c == 30 || c == 46); end
      checks++; if (d_done !== (c == 6 || c == 14 || c == 22 || c == 38)) begin errors++; $display("FAIL starve_ddone c=%0d got %b exp %b", c, d_done, c == 6 || c == 14 || c == 22 || c == 38); end
      if (c == 30) begin
        checks++; if (f_rdata !== mem_init(16'h0020)) begin errors++; $display("FAIL starve_frdata got %h exp %h", f_rdata, mem_init(16'h0020)); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    busy = 1'b0; starve_m = 0; free_at = cyc; last_f = '0; last_d = '0;
    exp_q.delete();
    rand_on = 1'b1;
    fork
      drive_f(25);
      drive_d(25);
    join
    repeat (10) @(posedge clk);
    @(negedge clk);
    rand_on = 1'b0;
    checks++;
    if (exp_q.size() != 0 || busy) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", exp_q.size() + int'(busy)); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence + report ----------------
  initial begin
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    l1_f_req = 1'b0; l1_f_addr = '0;
    mem_rdata = '0; l1_mem_rdata = '0;
    env_mem[16'h0040] = 16'hBEEF;
    test_reset();
    test_d_read();
    test_d_write();
    test_f_misaligned();
    test_reset_mid();
    test_lat1();
    test_starvation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified main memory between the fetch-side cache miss path (port F) and the memory-stage cache miss/writeback path (port D).
- Sits between the fetch and memory stages' cache controllers and the memory array.
- Grants one transaction at a time and sequences the fixed memory latency.
- Drives per-port stall and done so the pipeline's StallFetch/StallMem logic can consume them directly.

Parameters:
- MEM_LAT, 4, cycles from the mem_en cycle to the cycle in which mem_rdata is sampled (legal range 1..15).
- STARVE_MAX, 3, consecutive D grants with F waiting before F is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- f_req  in  1  fetch read request; held until f_done
- f_addr  in  16  fetch word address
- f_done  out  1  one-cycle pulse; f_rdata valid
- f_rdata  out  16  fetch read data
- f_stall  out  1  f_req & ~f_done
- d_req  in  1  data request; held until d_done
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_done  out  1  one-cycle pulse; d_rdata valid on reads
- d_rdata  out  16  data read data
- d_stall  out  1  d_req & ~d_done
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_wr  out  1  write enable, qualified by mem_en
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- err  out  1  pulses with done on a misaligned address
- owner_d  out  1  1 = current/last grant to D (debug)

Behaviour:
- Reset: clk and rst as named above. Synchronous, active-high. On reset:
  - state = IDLE, latency counter = 0, starve counter = 0.
  - All registered outputs = 0: mem_en, mem_wr, mem_addr, mem_wdata, f_done, d_done, f_rdata, d_rdata, err, owner_d.
  - Reset mid-transaction abandons it: no done pulse, and no mem_en follows.
- States:
  - IDLE: arbitrate. A request sampled here is new.
  - ISSUE: mem_en = 1 for exactly one cycle with the latched wr/addr/wdata; the counter loads MEM_LAT-1.
  - WAIT: counter decrements; at 0, sample mem_rdata into the owner's rdata register.
  - RESP: owner's done = 1 for one cycle.
  - HOLD: one idle cycle in which requests are ignored; requesters drop req here.
- Transitions:
  - IDLE → ISSUE on any request.
  - IDLE → RESP when the granted address has addr[0] = 1. In that case err = 1 with done, no mem_en, and rdata is unchanged.
  - ISSUE → WAIT.
  - WAIT → RESP when the counter reaches 0.
  - RESP → HOLD → IDLE.
  - For MEM_LAT = 1, WAIT lasts one cycle.
- Latency: request first high in IDLE cycle t:
  - mem_en in cycle t+1;
  - mem_rdata sampled at the end of cycle t+MEM_LAT+1;
  - done in cycle t+MEM_LAT+2;
  - next grant no earlier than cycle t+MEM_LAT+4.
- Writes use identical timing; d_rdata is unchanged on a write.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: D wins while starve < STARVE_MAX, and starve increments; otherwise F wins.
  - Any F grant clears starve.
  - A D grant with f_req low leaves starve unchanged.
  - Addr/wr/wdata are latched at grant; requester changes after grant are ignored.
- Stall outputs are combinational: f_stall/d_stall are high on the cycle req rises and stay high until the done cycle, where they are low.
- F never issues writes (mem_wr = 0 on F grants).

Decomposition:
- Shared package (mem_arb_pkg) holds:
  - state encodings IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3, HOLD = 4 (3 bits);
  - owner IDs OWN_F = 0, OWN_D = 1;
  - default MEM_LAT and STARVE_MAX constants.
- Sub-module arb_lat_ctr: loadable 4-bit down-counter with a zero flag. It is also reusable by the cache controllers.

Test Plan:
- D read alone, d_addr = 0x0040, memory returns 0xBEEF; req at cycle 0 → mem_en at cycle 1 with addr 0x0040, wr = 0; d_done at cycle 6 with d_rdata = 0xBEEF; f_done = 0 throughout.
- Both req at cycle 0, STARVE_MAX = 3, D re-requests after each done → D granted 3 times, the 4th grant goes to F (f_done at cycle 30), then starve = 0.
- D write, d_addr = 0x0100, d_wdata = 0x1234 → mem_en = 1, mem_wr = 1, mem_wdata = 0x1234 at cycle 1; d_done at cycle 6; d_rdata unchanged.
- F req with f_addr = 0x0003 → no mem_en; f_done = 1 and err = 1 at cycle 1; HOLD at cycle 2; IDLE at cycle 3.
- rst asserted at cycle 3 of a D read → state IDLE at cycle 4; no mem_en or d_done afterwards; outputs 0; a new F req at cycle 5 gets mem_en at cycle 6.
- MEM_LAT = 1, F read → mem_en at cycle 1, f_done at cycle 3; f_stall high at cycles 0–2 and low at cycle 3.
